// File: rtl/ae_frame_deserializer.sv
// Rebuilds (address, count) frames from the AE counter serial port, tags them with
// overflow/RTC flags and buffers them in a show-ahead FIFO behind a valid/ready port.
module ae_frame_deserializer #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             sl_in,
    input  logic [3:0]       addr_in,
    input  logic             ovf_glb_in,
    input  logic             ovf_rtc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_addr,
    output logic [WIDTH-1:0] out_count,
    output logic             out_ovf,
    output logic             out_rtc,
    output logic             frame_err,
    output logic             drop_pulse,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WIDTH + 2);
    localparam int EW = 4 + WIDTH + 2;
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    bitcnt, bitcnt_nxt;
    logic [3:0]       addr_q, addr_nxt;
    logic             ovf_acc, ovf_nxt;
    logic             eof;
    logic             good_frame;

    logic             rtc_prev;
    logic             rtc_sticky;
    logic             rtc_edge;

    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty;
    logic             pop, push, drop;

    always_comb begin
        state_nxt  = state;
        sreg_nxt   = sreg;
        bitcnt_nxt = bitcnt;
        addr_nxt   = addr_q;
        ovf_nxt    = ovf_acc;
        eof        = 1'b0;
        case (state)
            IDLE: begin
                if (sl_in) begin
                    state_nxt  = SHIFT;
                    sreg_nxt   = {{(WIDTH-1){1'b0}}, serial_in};
                    bitcnt_nxt = CW'(1);
                    addr_nxt   = addr_in;
                    ovf_nxt    = ovf_glb_in;
                end
            end
            SHIFT: begin
                if (sl_in) begin
                    sreg_nxt = {sreg[WIDTH-2:0], serial_in};
                    // Saturating one past WIDTH is enough to flag over-long frames.
                    if (bitcnt != CW'(WIDTH + 1)) begin
                        bitcnt_nxt = bitcnt + CW'(1);
                    end
                    ovf_nxt = ovf_acc | ovf_glb_in;
                end else begin
                    state_nxt = IDLE;
                    eof       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign good_frame = eof && (bitcnt == CW'(WIDTH)) && (addr_q != 4'd0);

    // Handshake: out_valid never depends on out_ready; the head transfers on any
    // rising edge where out_valid & out_ready, and out_* hold until it does.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push      = good_frame & (~full | pop);
    assign drop      = good_frame & full & ~pop;
    assign rtc_edge  = ovf_rtc_in & ~rtc_prev;

    assign {out_addr, out_count, out_ovf, out_rtc} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sreg       <= '0;
            bitcnt     <= '0;
            addr_q     <= '0;
            ovf_acc    <= 1'b0;
            rtc_prev   <= 1'b0;
            rtc_sticky <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_err  <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            bitcnt     <= bitcnt_nxt;
            addr_q     <= addr_nxt;
            ovf_acc    <= ovf_nxt;
            rtc_prev   <= ovf_rtc_in;
            frame_err  <= eof & ~good_frame;
            drop_pulse <= drop;
            // An edge coinciding with a push belongs to the next frame.
            if (push) begin
                rtc_sticky <= rtc_edge;
            end else if (rtc_edge) begin
                rtc_sticky <= 1'b1;
            end
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {addr_q, sreg, ovf_acc, rtc_sticky};
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ae_frame_deserializer.sv
// Bench for ae_frame_deserializer: directed scenarios plus randomized frames checked
// against a queue/occupancy reference model of the frame stream.
module tb_ae_frame_deserializer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             serial_in;
    logic             sl_in;
    logic [3:0]       addr_in;
    logic             ovf_glb_in;
    logic             ovf_rtc_in;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_addr;
    logic [WIDTH-1:0] out_count;
    logic             out_ovf;
    logic             out_rtc;
    logic             frame_err;
    logic             drop_pulse;
    logic [7:0]       drop_cnt;

    always #5 clk = ~clk;

    ae_frame_deserializer #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .sl_in(sl_in),
        .addr_in(addr_in), .ovf_glb_in(ovf_glb_in), .ovf_rtc_in(ovf_rtc_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_count(out_count), .out_ovf(out_ovf), .out_rtc(out_rtc),
        .frame_err(frame_err), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Stimulus control and end-of-frame announcement from the driver.
    int               ready_mode = 0;   // 0 hold low, 1 hold high, 2 random
    bit               rtc_rand   = 1'b0;
    bit               eof_pending = 1'b0;
    bit               eof_good    = 1'b0;
    logic [3:0]       eof_addr    = '0;
    logic [WIDTH-1:0] eof_data    = '0;
    bit               eof_ovf     = 1'b0;

    // Reference model: frame queue, occupancy, sticky RTC, drop counter.
    logic [WIDTH+5:0] exp_q[$];
    int               occ        = 0;
    bit               m_sticky   = 1'b0;
    bit               m_rtc_prev = 1'b0;
    bit               nxt_err    = 1'b0;
    bit               nxt_drop   = 1'b0;
    logic [7:0]       m_drop_cnt = '0;
    int               err_seen   = 0;
    int               drop_seen  = 0;
    int               pop_seen   = 0;

    // Scoreboard: check the state after the last edge, then predict the next edge.
    always @(negedge clk) begin : scoreboard
        logic [WIDTH+5:0] head;
        bit rtc_edge;
        bit full;
        bit pop;
        if (!rst_n) begin
            exp_q.delete();
            occ        = 0;
            m_sticky   = 1'b0;
            m_rtc_prev = 1'b0;
            nxt_err    = 1'b0;
            nxt_drop   = 1'b0;
            m_drop_cnt = '0;
        end else begin
            total++;
            if (out_valid !== ((occ > 0) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, out_valid, occ > 0);
            end
            if (occ > 0) begin
                head = exp_q[0];
                total++;
                if ({out_addr, out_count, out_ovf, out_rtc} !== head) begin
                    bad++;
                    $display("FAIL sb_head t=%0t got=%h/%h/%b/%b exp=%h/%h/%b/%b", $time,
                             out_addr, out_count, out_ovf, out_rtc,
                             head[WIDTH+5:WIDTH+2], head[WIDTH+1:2], head[1], head[0]);
                end
            end
            total++;
            if (frame_err !== nxt_err) begin
                bad++;
                $display("FAIL sb_frame_err t=%0t got=%b exp=%b", $time, frame_err, nxt_err);
            end
            total++;
            if (drop_pulse !== nxt_drop) begin
                bad++;
                $display("FAIL sb_drop_pulse t=%0t got=%b exp=%b", $time, drop_pulse, nxt_drop);
            end
            total++;
            if (drop_cnt !== m_drop_cnt) begin
                bad++;
                $display("FAIL sb_drop_cnt t=%0t got=%0d exp=%0d", $time, drop_cnt, m_drop_cnt);
            end
            if (frame_err === 1'b1) err_seen++;
            if (drop_pulse === 1'b1) drop_seen++;

            full = (occ == DEPTH);
            pop  = (occ > 0) && (out_ready === 1'b1);
            if (pop) begin
                void'(exp_q.pop_front());
                occ--;
                pop_seen++;
            end
            rtc_edge   = (ovf_rtc_in === 1'b1) && !m_rtc_prev;
            m_rtc_prev = (ovf_rtc_in === 1'b1);
            nxt_err    = eof_pending && !eof_good;
            nxt_drop   = 1'b0;
            if (eof_pending && eof_good && (!full || pop)) begin
                exp_q.push_back({eof_addr, eof_data, eof_ovf, m_sticky});
                occ++;
                m_sticky = rtc_edge;
            end else begin
                if (eof_pending && eof_good) begin
                    nxt_drop = 1'b1;
                    if (m_drop_cnt != 8'hFF) m_drop_cnt = m_drop_cnt + 8'd1;
                end
                if (rtc_edge) m_sticky = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (rtc_rand && ($urandom_range(0, 7) == 0)) ovf_rtc_in = ~ovf_rtc_in;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called at posedge+1; first bit goes out immediately, returns one cycle after
    // the end-of-frame edge so a following call gives exactly one sl_in=0 cycle.
    task automatic send_frame(input logic [3:0] a, input logic [WIDTH-1:0] d,
                              input int nbits, input int ovf_at);
        eof_pending = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) tick();
            sl_in      = 1'b1;
            addr_in    = a;
            serial_in  = (i < WIDTH) ? d[WIDTH-1-i] : 1'($urandom_range(0, 1));
            ovf_glb_in = (i == ovf_at);
        end
        tick();
        sl_in       = 1'b0;
        ovf_glb_in  = 1'b0;
        serial_in   = 1'($urandom_range(0, 1));
        eof_pending = 1'b1;
        eof_good    = (nbits == WIDTH) && (a != 4'd0);
        eof_addr    = a;
        eof_data    = d;
        eof_ovf     = (ovf_at >= 0) && (ovf_at < nbits);
        tick();
        eof_pending = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_addr, out_count, out_ovf, out_rtc, frame_err, drop_pulse, drop_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_in outputs got=%b/%h/%h/%b/%b/%b/%b/%0d exp=all zero", out_valid,
                     out_addr, out_count, out_ovf, out_rtc, frame_err, drop_pulse, drop_cnt);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({out_valid, out_addr, out_count, frame_err, drop_pulse, drop_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_after outputs got=%b/%h/%h/%b/%b/%0d exp=all zero", out_valid,
                     out_addr, out_count, frame_err, drop_pulse, drop_cnt);
        end
    endtask

    task automatic test_single_frame();
        ready_mode = 0;
        send_frame(4'd5, 8'hA3, 8, -1);
        total++;
        if ({out_valid, out_addr, out_count, out_ovf, out_rtc} !== {1'b1, 4'd5, 8'hA3, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL single_frame got=%b/%h/%h/%b/%b exp=1/5/a3/0/0", out_valid, out_addr,
                     out_count, out_ovf, out_rtc);
        end
        ready_mode = 1;
        idle(3);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_bad_length();
        int e0;
        e0 = err_seen;
        ready_mode = 1;
        send_frame(4'd2, 8'($urandom), 7, -1);
        idle(1);
        send_frame(4'd3, 8'($urandom), 9, -1);
        idle(2);
        total++;
        if ((err_seen - e0) != 2 || out_valid !== 1'b0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL bad_length errs=%0d valid=%b drops=%0d exp=2/0/0", err_seen - e0,
                     out_valid, drop_cnt);
        end
    endtask

    task automatic test_fifo_full_drop();
        int d0;
        d0 = drop_seen;
        ready_mode = 0;
        for (int a = 1; a <= 5; a++) send_frame(4'(a), 8'($urandom), 8, -1);
        idle(2);
        total++;
        if ((drop_seen - d0) != 1 || drop_cnt !== 8'd1) begin
            bad++;
            $display("FAIL full_drop pulses=%0d cnt=%0d exp=1/1", drop_seen - d0, drop_cnt);
        end
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_addr !== 4'(k)) begin
                bad++;
                $display("FAIL full_order valid=%b addr=%0d exp=1/%0d", out_valid, out_addr, k);
            end
            pop_one();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_empty got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_rtc_ovf_flags();
        ready_mode = 0;
        ovf_rtc_in = 1'b1;
        idle(2);
        send_frame(4'd3, 8'($urandom), 8, -1);
        send_frame(4'd4, 8'($urandom), 8, -1);
        send_frame(4'd6, 8'($urandom), 8, 3);
        ovf_rtc_in = 1'b0;
        idle(1);
        total++;
        if (out_addr !== 4'd3 || out_rtc !== 1'b1) begin
            bad++;
            $display("FAIL rtc_first addr=%0d rtc=%b exp=3/1", out_addr, out_rtc);
        end
        pop_one();
        total++;
        if (out_addr !== 4'd4 || out_rtc !== 1'b0 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL rtc_second addr=%0d rtc=%b ovf=%b exp=4/0/0", out_addr, out_rtc, out_ovf);
        end
        pop_one();
        total++;
        if (out_addr !== 4'd6 || out_ovf !== 1'b1 || out_rtc !== 1'b0) begin
            bad++;
            $display("FAIL ovf_frame addr=%0d ovf=%b rtc=%b exp=6/1/0", out_addr, out_ovf, out_rtc);
        end
        pop_one();
    endtask

    task automatic test_addr_zero();
        int e0;
        e0 = err_seen;
        ready_mode = 1;
        send_frame(4'd0, 8'h77, 8, -1);
        idle(2);
        total++;
        if ((err_seen - e0) != 1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL addr_zero errs=%0d valid=%b exp=1/0", err_seen - e0, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pop_seen;
        ready_mode = 1;
        send_frame(4'd7, 8'h11, 8, -1);
        send_frame(4'd8, 8'h22, 8, 0);
        send_frame(4'd15, 8'hFE, 8, 7);
        idle(3);
        total++;
        if ((pop_seen - p0) != 3 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back pops=%0d valid=%b exp=3/0", pop_seen - p0, out_valid);
        end
    endtask

    task automatic test_random();
        int r, nb, oa;
        rtc_rand   = 1'b1;
        ready_mode = 2;
        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 9);
            nb = (r < 7) ? 8 : (r == 7) ? 7 : (r == 8) ? 9 : $urandom_range(1, 12);
            oa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
            send_frame(4'($urandom_range(0, 15)), 8'($urandom), nb, oa);
            idle($urandom_range(0, 3));
        end
        rtc_rand   = 1'b0;
        ready_mode = 1;
        idle(8);
        total++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL random_drain left=%0d valid=%b exp=0/0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        ready_mode = 1;
        ovf_rtc_in = 1'b0;
        idle(2);
        sl_in   = 1'b1;
        addr_in = 4'd7;
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            tick();
        end
        rst_n = 1'b0;
        sl_in = 1'b0;
        idle(2);
        total++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state valid=%b drops=%0d err=%b exp=0/0/0", out_valid,
                     drop_cnt, frame_err);
        end
        rst_n = 1'b1;
        tick();
        e0 = err_seen;
        ready_mode = 0;
        send_frame(4'd9, 8'h5C, 8, -1);
        idle(1);
        total++;
        if ({out_valid, out_addr, out_count} !== {1'b1, 4'd9, 8'h5C} || err_seen != e0) begin
            bad++;
            $display("FAIL midreset_frame got=%b/%0d/%h errs=%0d exp=1/9/5c/0", out_valid,
                     out_addr, out_count, err_seen - e0);
        end
        pop_one();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_empty got=%b exp=0", out_valid);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        sl_in      = 1'b0;
        serial_in  = 1'b0;
        addr_in    = 4'd0;
        ovf_glb_in = 1'b0;
        ovf_rtc_in = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_single_frame();
        test_bad_length();
        test_fifo_full_drop();
        test_rtc_ovf_flags();
        test_addr_zero();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
